// File: rtl/day021_sample_window_stats.sv
// ---------------------------------------------------------------------------
// day021_sample_window_stats
//
// Read-domain consumer of the asynchronous sample FIFO. It pops signed
// samples while the FIFO is non-empty, collects WINDOW of them, and then
// presents min, max, sum and mean of that window on a valid/ready port.
// Everything runs on the FIFO read clock.
//
// Ports:
//   clk_i        read-domain clock (same as FIFO read side)
//   rst_i        asynchronous, active-high reset
//   empty_i      FIFO empty flag
//   data_i       FIFO read data, valid one cycle after an accepted pop
//   re_o         FIFO read enable (combinational pop request)
//   out_ready_i  downstream ready
//   out_valid_o  window result valid
//   min_o        smallest signed sample of the window
//   max_o        largest signed sample of the window
//   sum_o        signed sum of the window (DATA_W+LOG2_WIN bits)
//   mean_o       sum_o arithmetic-shifted right by LOG2_WIN (floor)
//
// WINDOW must be a power of two in the range 2..256 so that the mean is
// a plain arithmetic shift of the sum.
// ---------------------------------------------------------------------------
module day021_sample_window_stats #(
    parameter int DATA_W   = 16,
    parameter int WINDOW   = 4,
    parameter int LOG2_WIN = $clog2(WINDOW)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       empty_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       re_o,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          min_o,
    output logic [DATA_W-1:0]          max_o,
    output logic [DATA_W+LOG2_WIN-1:0] sum_o,
    output logic [DATA_W-1:0]          mean_o
);

    // The sum grows by LOG2_WIN bits so a full window of extreme samples
    // can never overflow; counters need one extra bit to hold WINDOW itself.
    localparam int SUM_W = DATA_W + LOG2_WIN;
    localparam int CNT_W = LOG2_WIN + 1;
    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         issue_cnt;
    logic [CNT_W-1:0]         cap_cnt;
    logic                     rd_pend;

    logic signed [DATA_W-1:0] acc_min;
    logic signed [DATA_W-1:0] acc_max;
    logic signed [SUM_W-1:0]  acc_sum;

    logic signed [DATA_W-1:0] sample;
    logic signed [SUM_W-1:0]  sample_ext;
    logic signed [DATA_W-1:0] nxt_min;
    logic signed [DATA_W-1:0] nxt_max;
    logic signed [SUM_W-1:0]  nxt_sum;

    // Pop request: only while filling, the FIFO has data and the window
    // has not yet issued all of its pops. Gated by reset so nothing is
    // popped (and then lost) while the block is held in reset.
    assign re_o = (state == FILL) && !empty_i && (issue_cnt < WIN_CNT) && !rst_i;

    // Next accumulator values if the current data_i is captured. The first
    // capture of a window seeds all three accumulators with the sample, so
    // stale values from the previous window never leak in.
    always_comb begin
        sample     = $signed(data_i);
        sample_ext = {{LOG2_WIN{data_i[DATA_W-1]}}, data_i};
        nxt_min    = acc_min;
        nxt_max    = acc_max;
        nxt_sum    = acc_sum;
        if (cap_cnt == '0) begin
            nxt_min = sample;
            nxt_max = sample;
            nxt_sum = sample_ext;
        end else begin
            nxt_min = (sample < acc_min) ? sample : acc_min;
            nxt_max = (sample > acc_max) ? sample : acc_max;
            nxt_sum = acc_sum + sample_ext;
        end
    end

    // Window FSM. FILL issues pops and captures data one cycle later
    // (rd_pend tracks the pop in flight). The capture of the last sample
    // registers the results straight from the next-state accumulators, so
    // the final sample is included on the same edge. HOLD keeps the result
    // stable until the downstream handshake, then restarts the window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= FILL;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            rd_pend     <= 1'b0;
            acc_min     <= '0;
            acc_max     <= '0;
            acc_sum     <= '0;
            out_valid_o <= 1'b0;
            min_o       <= '0;
            max_o       <= '0;
            sum_o       <= '0;
            mean_o      <= '0;
        end else begin
            case (state)
                FILL: begin
                    rd_pend <= re_o;
                    if (re_o) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (rd_pend) begin
                        acc_min <= nxt_min;
                        acc_max <= nxt_max;
                        acc_sum <= nxt_sum;
                        cap_cnt <= cap_cnt + CNT_W'(1);
                        if (cap_cnt == LAST_CNT) begin
                            min_o       <= nxt_min;
                            max_o       <= nxt_max;
                            sum_o       <= nxt_sum;
                            mean_o      <= DATA_W'(nxt_sum >>> LOG2_WIN);
                            out_valid_o <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    rd_pend <= 1'b0;
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        issue_cnt   <= '0;
                        cap_cnt     <= '0;
                        state       <= FILL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_day021_sample_window_stats.sv
// ---------------------------------------------------------------------------
// tb_day021_sample_window_stats
//
// Directed bench for day021_sample_window_stats (DATA_W=16, WINDOW=4).
// A queue stands in for the sample FIFO: empty_i follows the queue (plus an
// optional forced gap) and an accepted pop presents the next word on data_i
// one cycle later. Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_day021_sample_window_stats;

    logic        clk_i;
    logic        rst_i;
    logic        empty_i;
    logic [15:0] data_i;
    logic        re_o;
    logic        out_ready_i;
    logic        out_valid_o;
    logic [15:0] min_o;
    logic [15:0] max_o;
    logic [17:0] sum_o;
    logic [15:0] mean_o;

    logic [15:0] fifo_q[$];
    logic        gap;

    // Snapshot of DUT outputs taken mid-cycle (after empty_i settles).
    logic        snap_re;
    logic        snap_valid;
    logic [15:0] snap_min;
    logic [15:0] snap_max;
    logic [17:0] snap_sum;
    logic [15:0] snap_mean;

    int tests_run;
    int tests_failed;
    int n;
    int done;
    logic [4:0] re_trace;
    logic [5:0] valid_trace;

    day021_sample_window_stats #(
        .DATA_W (16),
        .WINDOW (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .empty_i     (empty_i),
        .data_i      (data_i),
        .re_o        (re_o),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .min_o       (min_o),
        .max_o       (max_o),
        .sum_o       (sum_o),
        .mean_o      (mean_o)
    );

    // 10 ns read clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Queue four samples into the FIFO model.
    task automatic applyStimulus(input int a, input int b, input int c, input int d);
        fifo_q.push_back(16'(a));
        fifo_q.push_back(16'(b));
        fifo_q.push_back(16'(c));
        fifo_q.push_back(16'(d));
    endtask

    // One read-clock cycle: drive empty_i at the falling edge, snapshot the
    // outputs, then after the rising edge present popped data on data_i.
    task automatic tick();
        @(negedge clk_i);
        empty_i = (fifo_q.size() == 0) || gap;
        #1;
        snap_re    = re_o;
        snap_valid = out_valid_o;
        snap_min   = min_o;
        snap_max   = max_o;
        snap_sum   = sum_o;
        snap_mean  = mean_o;
        @(posedge clk_i);
        #1;
        if (snap_re && fifo_q.size() != 0) begin
            data_i = fifo_q.pop_front();
        end
    endtask

    // Tick until a result is valid (bounded) and check the four results.
    task automatic runWindow(input string tag, input int emin, input int emax,
                             input int esum, input int emean, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!snap_valid && cycles < 200);
        checkOutput({tag, "_valid"}, longint'(snap_valid), 1);
        checkOutput({tag, "_min"},  longint'($signed(snap_min)),  emin);
        checkOutput({tag, "_max"},  longint'($signed(snap_max)),  emax);
        checkOutput({tag, "_sum"},  longint'($signed(snap_sum)),  esum);
        checkOutput({tag, "_mean"}, longint'($signed(snap_mean)), emean);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_i        = 1'b1;
        empty_i      = 1'b0;
        data_i       = '0;
        out_ready_i  = 1'b1;
        gap          = 1'b0;

        // Reset state: re_o must be gated by reset even with empty_i low.
        #2;
        checkOutput("rst_re",    longint'(re_o), 0);
        checkOutput("rst_valid", longint'(out_valid_o), 0);
        checkOutput("rst_min",   longint'(min_o), 0);
        checkOutput("rst_sum",   longint'(sum_o), 0);
        checkOutput("rst_mean",  longint'(mean_o), 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Basic window, back-to-back pops: 10,-3,7,2.
        applyStimulus(10, -3, 7, 2);
        for (int t = 0; t < 6; t++) begin
            tick();
            if (t < 5) re_trace[t] = snap_re;
            valid_trace[t] = snap_valid;
        end
        checkOutput("basic_re_pattern", longint'(re_trace), 5'b01111);
        checkOutput("basic_valid_pattern", longint'(valid_trace), 6'b100000);
        checkOutput("basic_min",  longint'($signed(snap_min)),  -3);
        checkOutput("basic_max",  longint'($signed(snap_max)),  10);
        checkOutput("basic_sum",  longint'($signed(snap_sum)),  16);
        checkOutput("basic_mean", longint'($signed(snap_mean)), 4);

        // Negative sum: mean floors toward minus infinity.
        applyStimulus(-1, -2, -2, -2);
        runWindow("neg", -2, -1, -7, -2, n);
        checkOutput("neg_latency", n, 6);

        // Extremes: full-scale positive then full-scale negative windows.
        applyStimulus(32767, 32767, 32767, 32767);
        applyStimulus(-32768, -32768, -32768, -32768);
        runWindow("maxpos", 32767, 32767, 131068, 32767, n);
        runWindow("maxneg", -32768, -32768, -131072, -32768, n);

        // Empty gap of three cycles after the second pop.
        applyStimulus(3, -5, 0, 6);
        n    = 0;
        done = 0;
        for (int t = 1; t <= 40 && done == 0; t++) begin
            gap = (t >= 3 && t <= 5);
            tick();
            if (t >= 3 && t <= 5) checkOutput("gap_re", longint'(snap_re), 0);
            if (snap_valid) begin
                done = 1;
                n    = t;
            end
        end
        gap = 1'b0;
        checkOutput("gap_latency", n, 9);
        checkOutput("gap_min",  longint'($signed(snap_min)),  -5);
        checkOutput("gap_max",  longint'($signed(snap_max)),  6);
        checkOutput("gap_sum",  longint'($signed(snap_sum)),  4);
        checkOutput("gap_mean", longint'($signed(snap_mean)), 1);

        // Backpressure: hold the result for five cycles with data waiting.
        out_ready_i = 1'b0;
        applyStimulus(5, 6, 7, 8);
        applyStimulus(1, 2, 3, 4);
        runWindow("bp", 5, 8, 26, 6, n);
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput("bp_hold_re",    longint'(snap_re), 0);
            checkOutput("bp_hold_valid", longint'(snap_valid), 1);
            checkOutput("bp_hold_sum",   longint'($signed(snap_sum)), 26);
            checkOutput("bp_hold_min",   longint'($signed(snap_min)), 5);
        end
        out_ready_i = 1'b1;
        tick();
        checkOutput("bp_hs_re", longint'(snap_re), 0);
        tick();
        checkOutput("bp_resume_re", longint'(snap_re), 1);
        runWindow("bp_next", 1, 4, 10, 2, n);

        // Asynchronous reset mid-window with a pop in flight.
        applyStimulus(9, 9, 9, 9);
        tick();
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("arst_re",    longint'(re_o), 0);
        checkOutput("arst_valid", longint'(out_valid_o), 0);
        checkOutput("arst_min",   longint'(min_o), 0);
        checkOutput("arst_max",   longint'(max_o), 0);
        checkOutput("arst_sum",   longint'(sum_o), 0);
        checkOutput("arst_mean",  longint'(mean_o), 0);
        fifo_q.delete();
        fifo_q.push_back(16'd7);
        tick();
        checkOutput("arst_hold_re", longint'(snap_re), 0);
        tick();
        rst_i = 1'b0;
        fifo_q.delete();
        applyStimulus(1, 1, 1, 1);
        runWindow("post_rst", 1, 1, 4, 1, n);
        checkOutput("post_rst_latency", n, 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
